ped_request_conditioner: RTL and testbench

Upstream front end of the TLC. It conditions the two raw, asynchronous pedestrian push-buttons into clean, latched request levels for the controller's ped_ns / ped_ew inputs. Per channel, it performs:
- 2-flop synchronisation
- counter-based debounce
- rising-edge detection on the debounced level
- request latching until the controller serves the request

Serving is signalled by the TLC's walk_ns / walk_ew outputs. A held or bouncing button produces exactly one request per press.

---
 rtl/ped_request_conditioner.sv | 70 +++++++
 tb/tb_ped_request_conditioner.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner: sync, debounce and latch two pedestrian buttons into TLC requests; STUCK_DETECT_EN adds stuck-button blocking
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_ns_raw,
  input  logic btn_ew_raw,
  input  logic walk_ns,
  input  logic walk_ew,
  output logic ped_ns,
  output logic ped_ew,
  output logic stuck_ns,
  output logic stuck_ew
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [1:0] raw, walk, ped, stuck;
  assign raw = {btn_ew_raw, btn_ns_raw};
  assign walk = {walk_ew, walk_ns};
  assign {ped_ew, ped_ns} = ped;
  assign {stuck_ew, stuck_ns} = stuck;
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("ped_request_conditioner: illegal DEBOUNCE_CYCLES/STUCK_CYCLES");
  end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic s1, s2, db, p, flip, rise, db_next, block;
    logic [CW-1:0] cnt;
    assign flip = (s2 != db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && s2;
    assign db_next = flip ? s2 : db;
`ifdef STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    logic [SW-1:0] scnt, scnt_next;
    logic st;
    // counts edges with db already high, so the rise edge itself is not counted
    assign scnt_next = !db_next ? '0 : (db && scnt != SW'(STUCK_CYCLES)) ? scnt + 1'b1 : scnt;
    assign block = scnt_next == SW'(STUCK_CYCLES);
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        scnt <= '0;
        st <= 1'b0;
      end else begin
        scnt <= scnt_next;
        st <= block;
      end
    end
    assign stuck[c] = st;
`else
    assign block = 1'b0;
    assign stuck[c] = 1'b0;
`endif
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        db <= 1'b0;
        cnt <= '0;
        p <= 1'b0;
      end else begin
        s1 <= raw[c];
        s2 <= s1;
        db <= db_next;
        cnt <= (s2 == db || flip) ? '0 : cnt + 1'b1;
        p <= (walk[c] || block) ? 1'b0 : rise ? 1'b1 : p;
      end
    end
    assign ped[c] = p;
  end
endmodule

// File: tb/tb_ped_request_conditioner.sv
// tb_ped_request_conditioner: table-driven vectors through a scoreboard queue, plus hand sequences for reset and long holds
module tb_ped_request_conditioner;
  logic clk = 0, rst_n = 0, btn_ns_raw = 0, btn_ew_raw = 0, walk_ns = 0, walk_ew = 0;
  logic ped_ns, ped_ew, stuck_ns, stuck_ew;
  always #5 clk = ~clk;

  ped_request_conditioner #(.DEBOUNCE_CYCLES(4), .STUCK_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .btn_ns_raw(btn_ns_raw), .btn_ew_raw(btn_ew_raw),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .ped_ns(ped_ns), .ped_ew(ped_ew),
    .stuck_ns(stuck_ns), .stuck_ew(stuck_ew)
  );

  typedef struct {
    logic rst_n, bn, be, wn, we;
    logic pn, pe, sn, se;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_checks = 0, n_pass = 0, row = 0;

  task automatic add(input logic r, bn, be, wn, we, pn, pe, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r, bn, be, wn, we, pn, pe, 1'b0, 1'b0});
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s row %0d: got %b expected %b", name, row, got, exp);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst_n = v.rst_n;
    btn_ns_raw = v.bn;
    btn_ew_raw = v.be;
    walk_ns = v.wn;
    walk_ew = v.we;
    sb.push_back(v);
    @(posedge clk);
    #1;
    row++;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
    end else begin
      e = sb.pop_front();
      chk("ped_ns", ped_ns, e.pn);
      chk("ped_ew", ped_ew, e.pe);
      chk("stuck_ns", stuck_ns, e.sn);
      chk("stuck_ew", stuck_ew, e.se);
    end
  endtask

  initial begin
    logic ep, es;
    add(0, 0, 0, 0, 0, 0, 0, 2);
    // single held press: request appears on the sixth edge, survives release, walk clears it
    add(1, 1, 0, 0, 0, 0, 0, 5);
    add(1, 1, 0, 0, 0, 1, 0, 3);
    add(1, 0, 0, 0, 0, 1, 0, 8);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 20; i++) add(1, logic'(i % 2), 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 8);
    // served while held: no re-request until release; 3-cycle press too short, 4-cycle press counts
    add(1, 1, 0, 0, 0, 0, 0, 5);
    add(1, 1, 0, 0, 0, 1, 0, 2);
    add(1, 1, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 10);
    add(1, 0, 0, 0, 0, 0, 0, 8);
    add(1, 1, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 6);
    add(1, 1, 0, 0, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 8);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    // simultaneous presses latch independently
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 1, 0, 0, 0, 0, 5);
    add(1, 1, 1, 0, 0, 1, 1, 2);
    add(1, 1, 1, 0, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 1, 0, 3);
    add(1, 1, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 8);
    foreach (tbl[i]) apply(tbl[i]);

    // reset while a latched request is held discards it; held button re-debounces
    for (int i = 1; i <= 6; i++) apply('{1, 1, 0, 0, 0, logic'(i == 6), 0, 0, 0});
    for (int i = 0; i < 2; i++) apply('{0, 1, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 1; i <= 7; i++) apply('{1, 1, 0, 0, 0, logic'(i >= 6), 0, 0, 0});

    // long hold on EW-free NS channel, then release
    for (int i = 0; i < 2; i++) apply('{0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 1; i <= 80; i++) begin
`ifdef STUCK_DETECT_EN
      es = logic'(i >= 70);
      ep = logic'(i >= 6 && i < 70);
`else
      es = 1'b0;
      ep = logic'(i >= 6);
`endif
      apply('{1, 1, 0, 0, 0, ep, 0, es, 0});
    end
    for (int i = 1; i <= 8; i++) begin
`ifdef STUCK_DETECT_EN
      es = logic'(i < 6);
      ep = 1'b0;
`else
      es = 1'b0;
      ep = 1'b1;
`endif
      apply('{1, 0, 0, 0, 0, ep, 0, es, 0});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
